// File: rtl/booth.sv
// Registered radix-4 Booth digit recoder with direction flip.
//
// Each cycle one overlapping Booth triplet is decoded into a sign/magnitude
// select code for the downstream partial-product / shift-add multiplexers.
// The code appears on the outputs one clock after the input is sampled.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset, clears all outputs
//   d0_a  in   [2:0] Booth triplet {b(2i+1), b(2i), b(2i-1)}
//              [3]   direction flip, 1 negates the recoded digit
//   c0    out  negate: the selected multiple is subtracted
//   c1    out  select x1 multiple
//   c2    out  select x2 multiple
module booth (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0_a,
  output logic       c0,
  output logic       c1,
  output logic       c2
);

  logic [2:0] trip;
  logic       flip;
  logic       one;
  logic       two;
  logic       booth_neg;
  logic       neg;

  logic c0_q, c0_d;
  logic c1_q, c1_d;
  logic c2_q, c2_d;

  assign trip = d0_a[2:0];
  assign flip = d0_a[3];

  always_comb begin
    one       = 1'b0;
    two       = 1'b0;
    booth_neg = 1'b0;
    neg       = 1'b0;

    // |digit| = 1 when the two low bits differ; |digit| = 2 for 011 / 100.
    one = trip[1] ^ trip[0];
    two = (trip == 3'b011) || (trip == 3'b100);

    booth_neg = trip[2] & (trip != 3'b111);

    // A zero digit carries no sign, so the flip cannot create a negative zero.
    neg = (booth_neg ^ flip) & (one | two);

    c0_d = neg;
    c1_d = one;
    c2_d = two;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_q <= 1'b0;
      c1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

  assign c0 = c0_q;
  assign c1 = c1_q;
  assign c2 = c2_q;

endmodule

// File: tb/tb_booth.sv
module tb_booth;

  logic       clk;
  logic       rst;
  logic [3:0] d0_a;
  logic       c0;
  logic       c1;
  logic       c2;

  int compared;
  int mismatched;

  booth dut (
    .clk  (clk),
    .rst  (rst),
    .d0_a (d0_a),
    .c0   (c0),
    .c1   (c1),
    .c2   (c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-derived {c0,c1,c2} for every d0_a value.
  function automatic logic [2:0] exp_code(input logic [3:0] v);
    case (v)
      4'b0000: exp_code = 3'b000;
      4'b0001: exp_code = 3'b010;
      4'b0010: exp_code = 3'b010;
      4'b0011: exp_code = 3'b001;
      4'b0100: exp_code = 3'b101;
      4'b0101: exp_code = 3'b110;
      4'b0110: exp_code = 3'b110;
      4'b0111: exp_code = 3'b000;
      4'b1000: exp_code = 3'b000;
      4'b1001: exp_code = 3'b110;
      4'b1010: exp_code = 3'b110;
      4'b1011: exp_code = 3'b101;
      4'b1100: exp_code = 3'b001;
      4'b1101: exp_code = 3'b010;
      4'b1110: exp_code = 3'b010;
      default: exp_code = 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [2:0] exp);
    logic [2:0] obs;
    obs = {c0, c1, c2};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    compared++;
    assert ((c1 & c2) === 1'b0) else begin
      mismatched++;
      $error("FAIL %s_onehot: observed c1=%b c2=%b expected not both 1", tag, c1, c2);
    end
    compared++;
    assert ((c0 & ~(c1 | c2)) === 1'b0) else begin
      mismatched++;
      $error("FAIL %s_negzero: observed c0=%b c1=%b c2=%b expected no negative zero",
             tag, c0, c1, c2);
    end
  endtask

  initial begin
    logic [3:0] prev;
    compared   = 0;
    mismatched = 0;
    rst  = 1'b0;
    d0_a = 4'b0011;

    // First edge at t=5 samples 0011 (+2).
    @(negedge clk);
    check("pre_reset", 3'b001);

    // Reset clears outputs without a clock edge.
    rst = 1'b1;
    #1;
    check("reset_async", 3'b000);
    @(negedge clk);
    check("reset_held", 3'b000);

    rst = 1'b0;
    @(negedge clk);
    check("reset_release", 3'b001);

    // Zero digits ignore the flip.
    d0_a = 4'b0000;
    @(negedge clk);
    check("zero_0000", 3'b000);
    d0_a = 4'b1111;
    @(negedge clk);
    check("zero_1111", 3'b000);

    d0_a = 4'b1001;
    @(negedge clk);
    check("flip_p1", 3'b110);
    d0_a = 4'b1100;
    @(negedge clk);
    check("flip_m2", 3'b001);

    // Exhaustive sweep, one new value per cycle, checked one cycle later.
    prev = 4'b0000;
    for (int v = 0; v < 16; v++) begin
      d0_a = 4'(v);
      if (v > 0) check($sformatf("sweep_%04b", prev), exp_code(prev));
      prev = 4'(v);
      @(negedge clk);
    end
    check($sformatf("sweep_%04b", prev), exp_code(prev));

    // Mid-stream reset between edges while output is 110.
    d0_a = 4'b0101;
    @(posedge clk);
    #1;
    check("mid_before", 3'b110);
    #2;
    rst = 1'b1;
    #1;
    check("mid_reset", 3'b000);
    @(negedge clk);
    rst = 1'b0;
    d0_a = 4'b0100;
    @(negedge clk);
    check("post_mid", 3'b101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
